uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_select.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: byte width, arbiter state encoding, index helper
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

    // (a + b) mod n, valid for a and b already in 0..n-1
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick of the first set request at or after a pointer
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts (wraps N-1 -> 0)
//   idx   : chosen requester index (0 when none found)
//   found : high when any request bit is set
module rr_select
    import uart_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[W'(wrap_add(int'(ptr), k, N))]) begin
                found = 1'b1;
                idx   = W'(wrap_add(int'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet-locking arbiter feeding bytes to one UART transmitter
//   clk_from_FPGA : clock, all state on rising edge
//   rst_from_FPGA : synchronous active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester byte streams (requester i at req_data[8i+7:8i])
//   tx_data/tx_start : registered byte and one-cycle transmit strobe
//   tx_busy       : transmitter busy, high from the cycle after tx_start until the stop bit ends
//   grant_id/grant_active : current owner and lock indication
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 1023
) (
    input  logic                        clk_from_FPGA,
    input  logic                        rst_from_FPGA,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        grant_active
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     grant_d;
    logic [IW-1:0]     rr_ptr, rr_ptr_d;
    logic [BW-1:0]     burst_cnt, burst_d;
    logic [HW-1:0]     hold_cnt, hold_d;
    logic              last_q, last_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic              tx_start_d;
    logic              rel;
    logic [IW-1:0]     sel_idx;
    logic              sel_found;
    logic              own_valid;
    logic              own_last;
    logic [BYTE_W-1:0] own_data;

    rr_select #(
        .N (NUM_REQ),
        .W (IW)
    ) u_rr_select (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Owner's stream, muxed with constant slices
    always_comb begin
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IW'(i)) own_data = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    assign own_valid    = req_valid[grant_id];
    assign own_last     = req_last[grant_id];
    assign grant_active = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_id;
        rr_ptr_d   = rr_ptr;
        burst_d    = burst_cnt;
        hold_d     = hold_cnt;
        last_d     = last_q;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        req_ready  = '0;
        rel        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found && !tx_busy) begin
                    grant_d = sel_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                req_ready[grant_id] = 1'b1;
                if (own_valid) begin
                    tx_data_d  = own_data;
                    tx_start_d = 1'b1;
                    last_d     = own_last;
                    burst_d    = burst_cnt + BW'(1);
                    state_d    = ST_WAIT;
                end else begin
                    // owner withdrew its byte; keep the lock and let the idle timer decide
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT: begin
                // tx_start is high only in the first WAIT cycle, before busy can have risen
                if (!tx_start && !tx_busy) begin
                    if (last_q || burst_cnt == BW'(MAX_BURST)) begin
                        rel = 1'b1;
                    end else begin
                        hold_d  = '0;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (own_valid) begin
                    state_d = ST_SEND;
                end else if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                    rel = 1'b1;
                end else begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rel) begin
            rr_ptr_d = IW'(wrap_add(int'(grant_id), 1, NUM_REQ));
            burst_d  = '0;
            hold_d   = '0;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk_from_FPGA) begin
        if (!rst_from_FPGA) begin
            state_q   <= ST_IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            hold_cnt  <= '0;
            last_q    <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_id  <= grant_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_d;
            hold_cnt  <= hold_d;
            last_q    <= last_d;
            tx_data   <= tx_data_d;
            tx_start  <= tx_start_d;
        end
    end

endmodule
